// File: rtl/pwm_dac_output.sv
// PWM DAC output stage: a small sample FIFO feeding a free-running PWM counter.
// The PWM counter takes one sample per period and holds the last duty if the FIFO runs dry.
module pwm_dac_output #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          pwm_out,
  output logic                          period_strobe,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [PW-1:0]     r_presc;
  logic [DATA_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_duty;
  logic              r_pwm;
  logic              r_strobe;
  logic              r_under;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_tick;
  logic              w_start;
  logic              w_pop;
  logic [DATA_W-1:0] w_duty_eff;

  // s_ready comes from the registered count only, so there is no s_valid -> s_ready path.
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = s_valid && !w_full;
  assign w_tick     = enable && (r_presc == PW'(PRESCALE - 1));
  assign w_start    = w_tick && (r_cnt == '0);
  assign w_pop      = w_start && !w_empty;
  assign w_duty_eff = w_pop ? r_mem[r_rd_ptr] : r_duty;

  assign s_ready       = !w_full;
  assign pwm_out       = r_pwm;
  assign period_strobe = r_strobe;
  assign underrun      = r_under;
  assign fill_level    = r_count;

  // Storage is left unreset; clearing the pointers and count discards its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc  <= '0;
      r_cnt    <= '0;
      r_duty   <= '0;
      r_pwm    <= 1'b0;
      r_strobe <= 1'b0;
      r_under  <= 1'b0;
    end else if (!enable) begin
      r_presc  <= '0;
      r_cnt    <= '0;
      r_pwm    <= 1'b0;
      r_strobe <= 1'b0;
      r_under  <= 1'b0;
    end else begin
      r_strobe <= w_start;
      r_under  <= w_start && w_empty;
      if (w_tick) begin
        r_presc <= '0;
        r_duty  <= w_duty_eff;
        r_pwm   <= (r_cnt < w_duty_eff);
        r_cnt   <= r_cnt + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

endmodule
